// File: rtl/guess_game_ctrl.sv
// Clocked 3-digit guessing game: button edges drive digit entry, LFSR picks the answer, LEDs show the compare result.
// Button actions land one cycle after sampling; a submit shows its result two cycles later and holds it HOLD_CYCLES cycles, with no backpressure.
module guess_game_ctrl #(
    parameter int          HOLD_CYCLES = 50000000,
    parameter int          MAX_TRIES   = 10,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  s,
    input  logic [2:0]  button,
    output logic [3:0]  digit1,
    output logic [3:0]  digit10,
    output logic [3:0]  digit100,
    output logic [1:0]  cursor,
    output logic [9:0]  banana,
    output logic [3:0]  tries,
    output logic [11:0] answer
);

    localparam int             TW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TW-1:0]  HOLD_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [3:0]     MAX_T     = 4'(MAX_TRIES);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_GEN   = 3'd1;
    localparam logic [2:0] ST_INPUT = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_SHOW  = 3'd4;
    localparam logic [2:0] ST_WIN   = 3'd5;
    localparam logic [2:0] ST_LOSE  = 3'd6;

    localparam logic [9:0] PAT_HIGH = 10'b1111100000;
    localparam logic [9:0] PAT_LOW  = 10'b0000011111;
    localparam logic [9:0] PAT_WIN  = 10'b1111111111;
    localparam logic [9:0] PAT_LOSE = 10'b1010101010;

    logic [2:0]    state;
    logic [15:0]   lfsr;
    logic [15:0]   lfsr_next;
    logic [2:0]    btn_q;
    logic [2:0]    rise;
    logic [TW-1:0] timer;
    logic          match;
    logic          mode_on;
    logic [11:0]   guess;

    function automatic logic [3:0] fold_digit(input logic [3:0] nib);
        return (nib >= 4'd10) ? (nib - 4'd10) : nib;
    endfunction

    function automatic logic [3:0] inc_digit(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : (d + 4'd1);
    endfunction

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign rise      = button & ~btn_q;
    assign mode_on   = (s == 4'b0010);
    // BCD digits below ten compare correctly as one unsigned number
    assign guess     = {digit100, digit10, digit1};

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr  <= LFSR_SEED;
            btn_q <= 3'b111;
        end else begin
            lfsr  <= lfsr_next;
            btn_q <= button;
        end

        if (rst || !mode_on) begin
            state    <= ST_IDLE;
            digit1   <= 4'd0;
            digit10  <= 4'd0;
            digit100 <= 4'd0;
            cursor   <= 2'd2;
            banana   <= 10'd0;
            tries    <= 4'd0;
            answer   <= 12'd0;
            timer    <= '0;
            match    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_GEN;
                ST_GEN: begin
                    answer   <= {fold_digit(lfsr[11:8]), fold_digit(lfsr[7:4]), fold_digit(lfsr[3:0])};
                    digit1   <= 4'd0;
                    digit10  <= 4'd0;
                    digit100 <= 4'd0;
                    cursor   <= 2'd2;
                    tries    <= 4'd0;
                    banana   <= 10'd0;
                    match    <= 1'b0;
                    state    <= ST_INPUT;
                end
                ST_INPUT: begin
                    if (rise[0]) begin
                        state <= ST_CHECK;
                    end else if (rise[2]) begin
                        case (cursor)
                            2'd0:    digit1   <= inc_digit(digit1);
                            2'd1:    digit10  <= inc_digit(digit10);
                            2'd2:    digit100 <= inc_digit(digit100);
                            default: ;
                        endcase
                    end else if (rise[1]) begin
                        cursor <= (cursor == 2'd2) ? 2'd0 : (cursor + 2'd1);
                    end
                end
                ST_CHECK: begin
                    if (guess > answer)      banana <= PAT_HIGH;
                    else if (guess < answer) banana <= PAT_LOW;
                    else                     banana <= PAT_WIN;
                    match <= (guess == answer);
                    tries <= (tries == 4'd15) ? tries : (tries + 4'd1);
                    timer <= HOLD_LOAD;
                    state <= ST_SHOW;
                end
                ST_SHOW: begin
                    if (timer == '0) begin
                        if (match) begin
                            state <= ST_WIN;
                        end else if (tries == MAX_T) begin
                            banana <= PAT_LOSE;
                            state  <= ST_LOSE;
                        end else begin
                            banana <= 10'd0;
                            state  <= ST_INPUT;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_WIN: begin
                    banana <= PAT_WIN;
                    if (rise[0]) state <= ST_GEN;
                end
                ST_LOSE: begin
                    banana <= PAT_LOSE;
                    if (rise[0]) state <= ST_GEN;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed bench for guess_game_ctrl with a short hold time and three allowed tries.
module tb_guess_game_ctrl;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  s;
    logic [2:0]  button;
    logic [3:0]  digit1, digit10, digit100, tries;
    logic [1:0]  cursor;
    logic [9:0]  banana;
    logic [11:0] answer;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_lfsr;
    logic [15:0] cap;
    logic [11:0] exp_ans;
    logic [11:0] g;

    guess_game_ctrl #(.HOLD_CYCLES(HOLD), .MAX_TRIES(3), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .s(s), .button(button),
        .digit1(digit1), .digit10(digit10), .digit100(digit100),
        .cursor(cursor), .banana(banana), .tries(tries), .answer(answer)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mnext(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic [3:0] fold(input logic [3:0] n);
        return (n > 4'd9) ? n - 4'd10 : n;
    endfunction

    function automatic logic [11:0] ans_of(input logic [15:0] v);
        return {fold(v[11:8]), fold(v[7:4]), fold(v[3:0])};
    endfunction

    function automatic logic [9:0] cmp_pat(input logic [11:0] gv, input logic [11:0] av);
        if (gv > av) return 10'b1111100000;
        if (gv < av) return 10'b0000011111;
        return 10'b1111111111;
    endfunction

    // Reference LFSR running in lock-step with the DUT from the same seed
    always @(posedge clk) m_lfsr <= rst ? 16'hACE1 : mnext(m_lfsr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [2:0] b);
        button = b;
        step();
        button = 3'b000;
        step();
    endtask

    task automatic hold_check(input string tag, input logic [9:0] pat, input logic [3:0] t,
                              input logic [9:0] after);
        press(3'b001);
        chk({tag, "_tries"}, 32'(tries), 32'(t));
        for (int i = 0; i < HOLD; i++) begin
            chk({tag, "_hold"}, 32'(banana), 32'(pat));
            button = (i == 1) ? 3'b100 : 3'b000;
            step();
        end
        button = 3'b000;
        chk({tag, "_after"}, 32'(banana), 32'(after));
    endtask

    initial begin
        rst = 1'b1;
        s = 4'b0010;
        button = 3'b111;
        repeat (3) step();
        chk("rst_digit1", 32'(digit1), 0);
        chk("rst_digit100", 32'(digit100), 0);
        chk("rst_cursor", 32'(cursor), 2);
        chk("rst_banana", 32'(banana), 0);
        chk("rst_tries", 32'(tries), 0);
        chk("rst_answer", 32'(answer), 0);

        // Seed ACE1 advances once to E270 before GEN, giving answer 270
        rst = 1'b0;
        step();
        step();
        chk("first_answer", 32'(answer), 32'h270);
        step();
        step();
        chk("held_digit100", 32'(digit100), 0);
        chk("held_cursor", 32'(cursor), 2);

        button = 3'b000;
        step();
        press(3'b100);
        chk("inc_first", 32'(digit100), 1);

        press(3'b010); chk("cursor_0", 32'(cursor), 0);
        press(3'b010); chk("cursor_1", 32'(cursor), 1);
        press(3'b010); chk("cursor_2", 32'(cursor), 2);

        for (int k = 2; k <= 10; k++) begin
            press(3'b100);
            chk("inc_wrap", 32'(digit100), 32'(k % 10));
        end

        // Round 1 against 270: 300 high, 200 low, 270 match on the last try
        repeat (3) press(3'b100);
        chk("guess_300", 32'(digit100), 3);
        hold_check("above", 10'b1111100000, 4'd1, 10'd0);
        chk("show_ignores_btn", 32'(digit100), 3);

        repeat (9) press(3'b100);
        chk("guess_200", 32'(digit100), 2);
        hold_check("below", 10'b0000011111, 4'd2, 10'd0);

        press(3'b010);
        press(3'b010);
        repeat (7) press(3'b100);
        chk("guess_tens", 32'(digit10), 7);
        hold_check("equal", 10'b1111111111, 4'd3, 10'b1111111111);
        step();
        chk("win_steady", 32'(banana), 32'h3FF);
        press(3'b100);
        chk("win_ignore_inc", 32'(digit100), 2);

        // Round 2: restart, then three wrong guesses lead to LOSE
        button = 3'b001;
        step();
        cap = m_lfsr;
        button = 3'b000;
        step();
        exp_ans = ans_of(cap);
        chk("gen2_answer", 32'(answer), 32'(exp_ans));
        chk("gen2_new", 32'(answer != 12'h270), 1);
        chk("gen2_tries", 32'(tries), 0);
        chk("gen2_digits", 32'({digit100, digit10, digit1}), 0);
        chk("gen2_cursor", 32'(cursor), 2);

        g = 12'h000;
        if (exp_ans == 12'h000) begin
            press(3'b100);
            g = 12'h100;
        end
        hold_check("lose1", cmp_pat(g, exp_ans), 4'd1, 10'd0);
        hold_check("lose2", cmp_pat(g, exp_ans), 4'd2, 10'd0);
        hold_check("lose3", cmp_pat(g, exp_ans), 4'd3, 10'b1010101010);
        step();
        chk("lose_steady", 32'(banana), 32'h2AA);
        press(3'b100);
        chk("lose_ignore_inc", 32'(digit100), 32'(g[11:8]));
        chk("lose_banana", 32'(banana), 32'h2AA);

        // Round 3: simultaneous submit+increment, then leave game mode mid-SHOW
        button = 3'b001;
        step();
        cap = m_lfsr;
        button = 3'b000;
        step();
        exp_ans = ans_of(cap);
        chk("gen3_answer", 32'(answer), 32'(exp_ans));
        button = 3'b101;
        step();
        chk("simul_digit", 32'(digit100), 0);
        button = 3'b000;
        step();
        chk("simul_tries", 32'(tries), 1);
        chk("simul_banana", 32'(banana), 32'(cmp_pat(12'h000, exp_ans)));
        s = 4'b0100;
        step();
        chk("exit_banana", 32'(banana), 0);
        chk("exit_tries", 32'(tries), 0);
        chk("exit_answer", 32'(answer), 0);
        chk("exit_digits", 32'({digit100, digit10, digit1}), 0);
        chk("exit_cursor", 32'(cursor), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
